// File: rtl/mem_req_throttle.sv
// mem_req_throttle
//   Buffering stage in front of the memory request channel. Requests from the
//   core side enter an in-order FIFO and are issued to memory from its head.
//   Reads are throttled so that no more than MAX_PENDING reads are outstanding.
//   Returned read responses (rsp_fire) release pending slots.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   req_in_*            : core-side request (valid/ready handshake)
//   req_out_*           : memory-side request, driven from the FIFO head
//   rsp_fire            : one read response consumed this cycle
//   pending_count       : number of outstanding reads
//   rsp_underflow       : sticky; a response arrived with nothing pending
module mem_req_throttle #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAG_WIDTH   = 8,
    parameter int DATA_SIZE   = DATA_WIDTH / 8,
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_PENDING = 8,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_in_valid,
    input  logic                  req_in_rw,
    input  logic [DATA_SIZE-1:0]  req_in_byteen,
    input  logic [ADDR_WIDTH-1:0] req_in_addr,
    input  logic [DATA_WIDTH-1:0] req_in_data,
    input  logic [TAG_WIDTH-1:0]  req_in_tag,
    output logic                  req_in_ready,
    output logic                  req_out_valid,
    output logic                  req_out_rw,
    output logic [DATA_SIZE-1:0]  req_out_byteen,
    output logic [ADDR_WIDTH-1:0] req_out_addr,
    output logic [DATA_WIDTH-1:0] req_out_data,
    output logic [TAG_WIDTH-1:0]  req_out_tag,
    input  logic                  req_out_ready,
    input  logic                  rsp_fire,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  rsp_underflow
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int ENTRY_W = 1 + DATA_SIZE + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]       wptr_q, wptr_d;
    logic [PTR_W:0]       rptr_q, rptr_d;
    logic [PTR_W:0]       count;
    logic                 full, empty;
    logic [ENTRY_W-1:0]   mem_q [QUEUE_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [QUEUE_DEPTH];
    logic [CNT_W-1:0]     pending_q, pending_d;
    logic                 underflow_q, underflow_d;
    // Held low through reset and set on the first clock afterwards, so the
    // producer sees ready low while reset is asserted.
    logic                 in_en_q, in_en_d;
    logic                 head_rw;
    logic                 push, pop, rd_issue;

    assign count = wptr_q - rptr_q;
    assign full  = (count == (PTR_W + 1)'(QUEUE_DEPTH));
    assign empty = (count == '0);

    assign {head_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag} =
        mem_q[rptr_q[PTR_W-1:0]];
    assign req_out_rw = head_rw;

    assign req_in_ready  = in_en_q && !full;
    // A head read blocked by the pending cap stalls everything behind it.
    assign req_out_valid = !empty && (head_rw || (pending_q < CNT_W'(MAX_PENDING)));
    assign pending_count = pending_q;
    assign rsp_underflow = underflow_q;

    assign push     = req_in_valid && req_in_ready;
    assign pop      = req_out_valid && req_out_ready;
    assign rd_issue = pop && !head_rw;

    always_comb begin
        in_en_d = 1'b1;
        wptr_d  = wptr_q + (PTR_W + 1)'(push);
        rptr_d  = rptr_q + (PTR_W + 1)'(pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q[PTR_W-1:0]] = {req_in_rw, req_in_byteen, req_in_addr,
                                        req_in_data, req_in_tag};
        end

        pending_d   = pending_q;
        underflow_d = underflow_q;
        if (rd_issue && !rsp_fire) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!rd_issue && rsp_fire) begin
            if (pending_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                pending_d = pending_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_en_q     <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            pending_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            in_en_q     <= in_en_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pending_q   <= pending_d;
            underflow_q <= underflow_d;
        end
    end

    // Payload storage needs no reset; only pointer-covered entries are read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
